// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - processor/memory request and return bus
interface mem_responder_if;
  logic [1:0]  proc2mem_command;
  logic [63:0] proc2mem_addr;
  logic [63:0] proc2mem_data;
  logic [1:0]  proc2mem_size;
  logic [3:0]  mem2proc_response;
  logic [63:0] mem2proc_data;
  logic [3:0]  mem2proc_tag;

  modport master (
    output proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size,
    input  mem2proc_response, mem2proc_data, mem2proc_tag
  );

  modport slave (
    input  proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size,
    output mem2proc_response, mem2proc_data, mem2proc_tag
  );
endinterface

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - tagged memory responder with fixed-latency load returns
module mem_responder #(
  parameter int LATENCY   = 4,
  parameter int MEM_WORDS = 256
) (
  input  logic         clock,
  input  logic         reset,
  mem_responder_if.slave bus
);

  localparam int AW = $clog2(MEM_WORDS);

  localparam logic [1:0] CMD_LOAD   = 2'd1;
  localparam logic [1:0] CMD_STORE  = 2'd2;
  localparam logic [1:0] SIZE_BYTE  = 2'd0;
  localparam logic [1:0] SIZE_HALF  = 2'd1;
  localparam logic [1:0] SIZE_WORD  = 2'd2;

  logic [63:0]         mem_q [MEM_WORDS];
  logic [AW-1:0]       word_idx;
  logic                in_range;
  logic                accept;
  logic                accept_load;
  logic                accept_store;
  logic [3:0]          tag_q, tag_d;
  logic [7:0]          byte_en;
  logic [63:0]         wdata;

  logic [LATENCY-1:0]  pipe_valid_q;
  logic [3:0]          pipe_tag_q  [LATENCY];
  logic [63:0]         pipe_data_q [LATENCY];
  logic [3:0]          out_tag_q;
  logic [63:0]         out_data_q;

  assign word_idx     = bus.proc2mem_addr[3+AW-1:3];
  assign in_range     = (bus.proc2mem_addr[63:3+AW] == '0);
  assign accept_load  = !reset && in_range && (bus.proc2mem_command == CMD_LOAD);
  assign accept_store = !reset && in_range && (bus.proc2mem_command == CMD_STORE);
  assign accept       = accept_load || accept_store;

  assign bus.mem2proc_response = accept ? tag_q : 4'd0;
  assign bus.mem2proc_tag      = reset ? 4'd0 : out_tag_q;
  assign bus.mem2proc_data     = reset ? 64'd0 : out_data_q;

  // Tag 0 means "nothing", so the counter cycles 1..15 only.
  always_comb begin
    tag_d = tag_q;
    if (accept) begin
      tag_d = (tag_q == 4'd15) ? 4'd1 : tag_q + 4'd1;
    end
  end

  // Replicate the store data across all lanes; byte_en picks the lane.
  always_comb begin
    byte_en = 8'hFF;
    wdata   = bus.proc2mem_data;
    case (bus.proc2mem_size)
      SIZE_BYTE: begin
        byte_en = 8'b0000_0001 << bus.proc2mem_addr[2:0];
        wdata   = {8{bus.proc2mem_data[7:0]}};
      end
      SIZE_HALF: begin
        byte_en = 8'b0000_0011 << {bus.proc2mem_addr[2:1], 1'b0};
        wdata   = {4{bus.proc2mem_data[15:0]}};
      end
      SIZE_WORD: begin
        byte_en = bus.proc2mem_addr[2] ? 8'hF0 : 8'h0F;
        wdata   = {2{bus.proc2mem_data[31:0]}};
      end
      default: begin
        byte_en = 8'hFF;
        wdata   = bus.proc2mem_data;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (accept_store) begin
      for (int b = 0; b < 8; b++) begin
        if (byte_en[b]) begin
          mem_q[word_idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tag_q        <= 4'd1;
      pipe_valid_q <= '0;
      out_tag_q    <= 4'd0;
      out_data_q   <= 64'd0;
    end else begin
      tag_q <= tag_d;
      for (int i = LATENCY - 1; i > 0; i--) begin
        pipe_valid_q[i] <= pipe_valid_q[i-1];
      end
      pipe_valid_q[0] <= accept_load;
      out_tag_q       <= pipe_valid_q[LATENCY-1] ? pipe_tag_q[LATENCY-1] : 4'd0;
      out_data_q      <= pipe_valid_q[LATENCY-1] ? pipe_data_q[LATENCY-1] : 64'd0;
    end
  end

  // Payload stages carry no reset; their valid bits gate everything.
  always_ff @(posedge clock) begin
    pipe_tag_q[0]  <= tag_q;
    pipe_data_q[0] <= mem_q[word_idx];
    for (int i = 1; i < LATENCY; i++) begin
      pipe_tag_q[i]  <= pipe_tag_q[i-1];
      pipe_data_q[i] <= pipe_data_q[i-1];
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed vector bench for mem_responder
module tb_mem_responder;

  localparam logic [1:0] NONE = 2'd0, LD = 2'd1, ST = 2'd2, RSV = 2'd3;
  localparam logic [1:0] SB = 2'd0, SH = 2'd1, SW = 2'd2, SD = 2'd3;

  typedef struct {
    logic [1:0]  cmd;
    logic [63:0] addr;
    logic [63:0] data;
    logic [1:0]  size;
    logic [3:0]  resp;
    logic [3:0]  tag;
    logic [63:0] rdata;
  } vec_t;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_fail;
  vec_t vecs [25];

  mem_responder_if bus ();

  mem_responder #(.LATENCY(4), .MEM_WORDS(256)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic vec_t mk(input logic [1:0] cmd, input logic [63:0] addr,
                              input logic [63:0] data, input logic [1:0] size,
                              input logic [3:0] resp, input logic [3:0] tag,
                              input logic [63:0] rdata);
    vec_t v;
    v.cmd = cmd; v.addr = addr; v.data = data; v.size = size;
    v.resp = resp; v.tag = tag; v.rdata = rdata;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic rst, input logic [1:0] cmd, input logic [63:0] addr,
                      input logic [63:0] data, input logic [1:0] size);
    @(negedge clock);
    reset                = rst;
    bus.proc2mem_command = cmd;
    bus.proc2mem_addr    = addr;
    bus.proc2mem_data    = data;
    bus.proc2mem_size    = size;
    #2;
  endtask

  task automatic check_idle_out(input string name);
    check({name, "_tag"}, 64'(bus.mem2proc_tag), 64'd0);
    check({name, "_data"}, bus.mem2proc_data, 64'd0);
  endtask

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      step(1'b1, LD, 64'h40, 64'd0, SD);
      check("rst_resp", 64'(bus.mem2proc_response), 64'd0);
      check_idle_out("rst");
    end
  endtask

  initial begin
    int exp_tag;
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    bus.proc2mem_command = NONE;
    bus.proc2mem_addr    = '0;
    bus.proc2mem_data    = '0;
    bus.proc2mem_size    = SD;

    // Row k drives cycle k; a load in row k returns in row k+5.
    vecs[0]  = mk(ST,   64'h40,  64'h1122334455667788, SD, 4'd1,  4'd0,  64'h0);
    vecs[1]  = mk(LD,   64'h40,  64'h0,                SD, 4'd2,  4'd0,  64'h0);
    vecs[2]  = mk(NONE, 64'h40,  64'h0,                SD, 4'd0,  4'd0,  64'h0);
    vecs[3]  = mk(ST,   64'h40,  64'h0,                SD, 4'd3,  4'd0,  64'h0);
    vecs[4]  = mk(ST,   64'h43,  64'hFFFF_FFFF_FFFF_FFAB, SB, 4'd4, 4'd0, 64'h0);
    vecs[5]  = mk(LD,   64'h40,  64'h0,                SD, 4'd5,  4'd0,  64'h0);
    vecs[6]  = mk(ST,   64'h46,  64'h0000_0000_1234_BEEF, SH, 4'd6, 4'd2, 64'h1122334455667788);
    vecs[7]  = mk(LD,   64'h40,  64'h0,                SD, 4'd7,  4'd0,  64'h0);
    vecs[8]  = mk(ST,   64'h50,  64'hFFFF_FFFF_FFFF_FFFF, SD, 4'd8, 4'd0, 64'h0);
    vecs[9]  = mk(ST,   64'h54,  64'hAAAA_AAAA_1234_5678, SW, 4'd9, 4'd0, 64'h0);
    vecs[10] = mk(LD,   64'h800, 64'h0,                SD, 4'd0,  4'd5,  64'h0000_0000_AB00_0000);
    vecs[11] = mk(RSV,  64'h40,  64'h0,                SD, 4'd0,  4'd0,  64'h0);
    vecs[12] = mk(LD,   64'h57,  64'h0,                SB, 4'd10, 4'd7,  64'hBEEF_0000_AB00_0000);
    vecs[13] = mk(ST,   64'h7F8, 64'hDEAD_BEEF_0BAD_F00D, SD, 4'd11, 4'd0, 64'h0);
    vecs[14] = mk(LD,   64'h7FF, 64'h0,                SH, 4'd12, 4'd0,  64'h0);
    vecs[15] = mk(LD,   64'h40,  64'h0,                SD, 4'd13, 4'd0,  64'h0);
    vecs[16] = mk(LD,   64'h50,  64'h0,                SD, 4'd14, 4'd0,  64'h0);
    vecs[17] = mk(LD,   64'h40,  64'h0,                SD, 4'd15, 4'd10, 64'h1234_5678_FFFF_FFFF);
    vecs[18] = mk(LD,   64'h50,  64'h0,                SD, 4'd1,  4'd0,  64'h0);
    vecs[19] = mk(NONE, 64'h0,   64'h0,                SD, 4'd0,  4'd12, 64'hDEAD_BEEF_0BAD_F00D);
    vecs[20] = mk(NONE, 64'h0,   64'h0,                SD, 4'd0,  4'd13, 64'hBEEF_0000_AB00_0000);
    vecs[21] = mk(NONE, 64'h0,   64'h0,                SD, 4'd0,  4'd14, 64'h1234_5678_FFFF_FFFF);
    vecs[22] = mk(NONE, 64'h0,   64'h0,                SD, 4'd0,  4'd15, 64'hBEEF_0000_AB00_0000);
    vecs[23] = mk(NONE, 64'h0,   64'h0,                SD, 4'd0,  4'd1,  64'h1234_5678_FFFF_FFFF);
    vecs[24] = mk(NONE, 64'h0,   64'h0,                SD, 4'd0,  4'd0,  64'h0);

    do_reset(2);

    for (int k = 0; k < 25; k++) begin
      step(1'b0, vecs[k].cmd, vecs[k].addr, vecs[k].data, vecs[k].size);
      check($sformatf("vec%0d_resp", k), 64'(bus.mem2proc_response), 64'(vecs[k].resp));
      check($sformatf("vec%0d_tag", k), 64'(bus.mem2proc_tag), 64'(vecs[k].tag));
      check($sformatf("vec%0d_data", k), bus.mem2proc_data, vecs[k].rdata);
    end

    // Sixteen back-to-back loads: tags wrap 15 -> 1, returns on consecutive cycles.
    do_reset(1);
    for (int c = 0; c < 23; c++) begin
      if (c < 16) step(1'b0, LD, 64'h50, 64'h0, SD);
      else        step(1'b0, NONE, 64'h0, 64'h0, SD);
      check($sformatf("burst%0d_resp", c), 64'(bus.mem2proc_response),
            (c < 16) ? 64'((c % 15) + 1) : 64'd0);
      exp_tag = (c >= 5 && c < 21) ? ((c - 5) % 15) + 1 : 0;
      check($sformatf("burst%0d_tag", c), 64'(bus.mem2proc_tag), 64'(exp_tag));
      check($sformatf("burst%0d_data", c), bus.mem2proc_data,
            (exp_tag != 0) ? 64'h1234_5678_FFFF_FFFF : 64'd0);
    end

    // Loads in flight when reset pulses must never come back.
    for (int c = 0; c < 3; c++) begin
      step(1'b0, LD, 64'h40, 64'h0, SD);
      check($sformatf("flush_ld%0d_resp", c), 64'(bus.mem2proc_response), 64'(c + 2));
    end
    step(1'b0, NONE, 64'h0, 64'h0, SD);
    do_reset(1);
    for (int c = 0; c < 8; c++) begin
      step(1'b0, NONE, 64'h0, 64'h0, SD);
      check_idle_out($sformatf("flush_idle%0d", c));
    end
    step(1'b0, LD, 64'h40, 64'h0, SD);
    check("post_reset_resp", 64'(bus.mem2proc_response), 64'd1);
    for (int c = 0; c < 4; c++) step(1'b0, NONE, 64'h0, 64'h0, SD);
    step(1'b0, NONE, 64'h0, 64'h0, SD);
    check("post_reset_tag", 64'(bus.mem2proc_tag), 64'd1);
    check("post_reset_data", bus.mem2proc_data, 64'hBEEF_0000_AB00_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
